mips_processor: RTL and testbench
=================================

Name: mips_processor

Overview:
- Single-cycle 32-bit MIPS subset processor; top-level simulation target with only clock and reset pins.
- Contains an instruction ROM, a controller and datapath (with a 32x32 register file) and a word-addressed data RAM.
- Programs are preloaded into the ROM by the bench. Results are checked by reading the register file directly.
- Instance hierarchy is fixed for bench access:
  - ROM array: imem.INSTRROM
  - Register array: mips.dp.gpr.registers[0:31]

Parameters:
- IMEM_WORDS, 64, depth of instruction ROM in 32-bit words, indexed by PC[31:2] modulo depth.
- DMEM_WORDS, 64, depth of data RAM in 32-bit words, indexed by address[31:2] modulo depth.

Ports:
- clk  input  1  rising-edge clock; all state updates occur on this edge.
- reset  input  1  synchronous, active-high reset.

Behaviour:
- Reset: on a rising edge with reset=1, PC <= 0 and HI/LO <= 0. Register file, data RAM and ROM are NOT cleared, so bench-preloaded values survive reset.
- One instruction completes per clock:
  - Instruction is fetched combinationally from ROM[PC>>2].
  - Register, PC, memory and HI/LO writes occur on the next rising edge.
- Register file: two asynchronous read ports, one synchronous write port. Register 0 always reads 0 and writes to it are discarded.
- Default next PC is PC+4, with 32-bit wrap.
- R-type (opcode 000000), selected by funct:
  - add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed compare; result 1 or 0). rd <= result.
  - jr 001000: PC <= rs.
  - Overflow is ignored; arithmetic wraps modulo 2^32.
- I-type:
  - addi 001000: sign-extended immediate.
  - ori 001101: zero-extended immediate.
  - lui 001111: rt <= imm<<16.
  - lw 100011: rt <= RAM[(rs+sext(imm))>>2].
  - sw 101011: RAM[...] <= rt.
  - beq 000100: if rs==rt, PC <= PC+4+(sext(imm)<<2).
  - bltz 000001 with rt field 00000: if rs is signed negative, PC <= PC+4+(sext(imm)<<2). rs=0 does not branch.
- J-type:
  - j 000010: PC <= {PC+4[31:28], target, 2'b00}.
  - jal 000011: same PC update, and r31 <= PC+4.
- Memory addressing: lw/sw use word addressing; the low two address bits are ignored. RAM read is combinational.
- Unrecognised opcode/funct executes as a NOP: no register, RAM or HI/LO write; PC+4.
- Fetch from unloaded ROM words (X) must not corrupt state beyond what the X propagates; benches stop before that point.
- Simultaneous reset and instruction: reset wins; the instruction at the current PC does not commit any write.

Optional Feature:
- Macro MUL_EN.
- Defined:
  - multu (R-type, funct 011001): {HI,LO} <= rs*rt as unsigned 64-bit.
  - mfhi (funct 010000): rd <= HI.
  - mflo (funct 010010): rd <= LO.
  - HI/LO are reset to 0.
- Undefined: these three functs execute as NOP and no HI/LO registers are built.

Test Plan:
- Constants: preload regs 1-31 = 0xcafebabe. Program lui $1,0x1234; ori $1,$1,0x5678; addi $2,$0,-1; reset high 5 time units, then 3 cycles -> $1=0x12345678, $2=0xffffffff, others 0xcafebabe.
- Branch-less-than-zero: addi $1,$0,-5; bltz $1,+1; addi $2,$0,7 (skipped); addi $3,$0,9 -> $1=0xfffffffb, $2=0xcafebabe, $3=0x00000009. Repeat with $1=+5 -> $2=0x7 (branch not taken).
- Function call: jal to word 3; addi $4,$0,1 after return; callee addi $5,$0,2; jr $31 -> $31=0x00000004, $5=0x2, $4=0x1.
- Fibonacci loop: loop using add/addi/beq with count 10 -> final register holds 0x00000037 (55); $0 remains 0 after an attempted write of 0x1.
- Memory: addi $1,$0,0x55; sw $1,8($0); lw $2,8($0) -> $2=0x55. Assert reset mid-program -> PC restarts at 0 and registers keep their values.
- Multiply (MUL_EN): $1=0x00010000, $2=0x00030000; multu; mfhi $3; mflo $4 -> $3=0x00000003, $4=0x00000000. Without MUL_EN, $3 and $4 keep 0xcafebabe.

Source files
------------

// File: rtl/mips_processor_if.sv
// rtl/mips_processor_if.sv - fetch and data-memory bus between the core and its memories
interface mips_processor_if;
   logic [31:0] pc;
   logic [31:0] instr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        we;

   modport master (output pc, addr, wdata, we, input instr, rdata);
   modport slave  (input pc, addr, wdata, we, output instr, rdata);
endinterface

// File: rtl/mips_processor.sv
// rtl/mips_processor.sv - single-cycle MIPS subset: ROM, controller, datapath, data RAM
// Optional multiply support (multu/mfhi/mflo with HI/LO) is enabled by defining MUL_EN.
module mips_regfile (
   input  logic        clk,
   input  logic        we,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);
   logic [31:0] registers [0:31];

   always_ff @(posedge clk)
      if (we && wa != 5'd0) registers[wa] <= wd;

   assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];
endmodule

// aluop: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 pass b; wbsel: 0 alu, 1 mem, 2 pc+4, 3 hi, 4 lo
module mips_controller (
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic [4:0] rt,
   output logic       regwrite,
   output logic [1:0] regdst,
   output logic [1:0] bsel,
   output logic [2:0] aluop,
   output logic [2:0] wbsel,
   output logic       memwrite,
   output logic       beq,
   output logic       bltz,
   output logic       jump,
`ifdef MUL_EN
   output logic       hilo_we,
`endif
   output logic       jr
);
   always_comb begin
      regwrite = 1'b0;
      regdst   = 2'd0;
      bsel     = 2'd0;
      aluop    = 3'd0;
      wbsel    = 3'd0;
      memwrite = 1'b0;
      beq      = 1'b0;
      bltz     = 1'b0;
      jump     = 1'b0;
      jr       = 1'b0;
`ifdef MUL_EN
      hilo_we  = 1'b0;
`endif
      case (op)
         6'b000000: begin
            case (funct)
               6'b100000: begin regwrite = 1'b1; regdst = 2'd1; aluop = 3'd0; end
               6'b100010: begin regwrite = 1'b1; regdst = 2'd1; aluop = 3'd1; end
               6'b100100: begin regwrite = 1'b1; regdst = 2'd1; aluop = 3'd2; end
               6'b100101: begin regwrite = 1'b1; regdst = 2'd1; aluop = 3'd3; end
               6'b101010: begin regwrite = 1'b1; regdst = 2'd1; aluop = 3'd4; end
               6'b001000: jr = 1'b1;
`ifdef MUL_EN
               6'b011001: hilo_we = 1'b1;
               6'b010000: begin regwrite = 1'b1; regdst = 2'd1; wbsel = 3'd3; end
               6'b010010: begin regwrite = 1'b1; regdst = 2'd1; wbsel = 3'd4; end
`endif
               default: ;
            endcase
         end
         6'b001000: begin regwrite = 1'b1; bsel = 2'd1; aluop = 3'd0; end
         6'b001101: begin regwrite = 1'b1; bsel = 2'd2; aluop = 3'd3; end
         6'b001111: begin regwrite = 1'b1; bsel = 2'd3; aluop = 3'd5; end
         6'b100011: begin regwrite = 1'b1; bsel = 2'd1; wbsel = 3'd1; end
         6'b101011: begin memwrite = 1'b1; bsel = 2'd1; end
         6'b000100: beq = 1'b1;
         6'b000001: bltz = (rt == 5'd0);
         6'b000010: jump = 1'b1;
         6'b000011: begin jump = 1'b1; regwrite = 1'b1; regdst = 2'd2; wbsel = 3'd2; end
         default: ;
      endcase
   end
endmodule

module mips_datapath (
   input  logic       clk,
   input  logic       reset,
   input  logic       regwrite,
   input  logic [1:0] regdst,
   input  logic [1:0] bsel,
   input  logic [2:0] aluop,
   input  logic [2:0] wbsel,
   input  logic       memwrite,
   input  logic       beq,
   input  logic       bltz,
   input  logic       jump,
`ifdef MUL_EN
   input  logic       hilo_we,
`endif
   input  logic       jr,
   mips_processor_if.master bus
);
   logic [31:0] pc, pc4, pcbr, pcnext, rs_v, rt_v, b, alu, wd, imm_s;
   logic [4:0]  wa;
   logic        taken;

   assign pc4   = pc + 32'd4;
   assign imm_s = {{16{bus.instr[15]}}, bus.instr[15:0]};
   assign pcbr  = pc4 + {imm_s[29:0], 2'b00};

`ifdef MUL_EN
   logic [31:0] hi, lo;
   always_ff @(posedge clk)
      if (reset)        {hi, lo} <= 64'd0;
      else if (hilo_we) {hi, lo} <= {32'd0, rs_v} * {32'd0, rt_v};
`endif

   always_comb begin
      case (bsel)
         2'd1:    b = imm_s;
         2'd2:    b = {16'd0, bus.instr[15:0]};
         2'd3:    b = {bus.instr[15:0], 16'd0};
         default: b = rt_v;
      endcase
   end

   always_comb begin
      alu = rs_v + b;
      case (aluop)
         3'd1:    alu = rs_v - b;
         3'd2:    alu = rs_v & b;
         3'd3:    alu = rs_v | b;
         3'd4:    alu = {31'd0, $signed(rs_v) < $signed(b)};
         3'd5:    alu = b;
         default: ;
      endcase
   end

   always_comb begin
      wd = alu;
      case (wbsel)
         3'd1:    wd = bus.rdata;
         3'd2:    wd = pc4;
`ifdef MUL_EN
         3'd3:    wd = hi;
         3'd4:    wd = lo;
`endif
         default: ;
      endcase
   end

   always_comb begin
      case (regdst)
         2'd1:    wa = bus.instr[15:11];
         2'd2:    wa = 5'd31;
         default: wa = bus.instr[20:16];
      endcase
   end

   // Reset suppresses every architectural write of the instruction currently at PC.
   mips_regfile gpr (
      .clk (clk),
      .we  (regwrite & ~reset),
      .ra1 (bus.instr[25:21]),
      .ra2 (bus.instr[20:16]),
      .wa  (wa),
      .wd  (wd),
      .rd1 (rs_v),
      .rd2 (rt_v)
   );

   assign taken  = (beq && rs_v == rt_v) || (bltz && rs_v[31]);
   assign pcnext = jr    ? rs_v :
                   jump  ? {pc4[31:28], bus.instr[25:0], 2'b00} :
                   taken ? pcbr : pc4;

   always_ff @(posedge clk)
      if (reset) pc <= 32'd0;
      else       pc <= pcnext;

   assign bus.pc    = pc;
   assign bus.addr  = alu;
   assign bus.wdata = rt_v;
   assign bus.we    = memwrite & ~reset;
endmodule

module mips_core (
   input logic clk,
   input logic reset,
   mips_processor_if.master bus
);
   logic       regwrite, memwrite, beq, bltz, jump, jr;
   logic [1:0] regdst, bsel;
   logic [2:0] aluop, wbsel;
`ifdef MUL_EN
   logic       hilo_we;
`endif

   mips_controller c (
      .op(bus.instr[31:26]), .funct(bus.instr[5:0]), .rt(bus.instr[20:16]),
      .regwrite(regwrite), .regdst(regdst), .bsel(bsel), .aluop(aluop), .wbsel(wbsel),
      .memwrite(memwrite), .beq(beq), .bltz(bltz), .jump(jump),
`ifdef MUL_EN
      .hilo_we(hilo_we),
`endif
      .jr(jr)
   );

   mips_datapath dp (
      .clk(clk), .reset(reset),
      .regwrite(regwrite), .regdst(regdst), .bsel(bsel), .aluop(aluop), .wbsel(wbsel),
      .memwrite(memwrite), .beq(beq), .bltz(bltz), .jump(jump),
`ifdef MUL_EN
      .hilo_we(hilo_we),
`endif
      .jr(jr), .bus(bus)
   );
endmodule

module mips_imem #(parameter int WORDS = 64) (
   mips_processor_if.slave bus
);
   localparam int AW = $clog2(WORDS);
   logic [31:0] INSTRROM [0:WORDS-1];
   logic [29:0] widx;

   assign widx      = bus.pc[31:2] % 30'(WORDS);
   assign bus.instr = INSTRROM[widx[AW-1:0]];
endmodule

module mips_dmem #(parameter int WORDS = 64) (
   input logic clk,
   mips_processor_if.slave bus
);
   localparam int AW = $clog2(WORDS);
   logic [31:0] ram [0:WORDS-1];
   logic [29:0] widx;

   assign widx      = bus.addr[31:2] % 30'(WORDS);
   assign bus.rdata = ram[widx[AW-1:0]];

   always_ff @(posedge clk)
      if (bus.we) ram[widx[AW-1:0]] <= bus.wdata;
endmodule

module mips_processor #(
   parameter int IMEM_WORDS = 64,
   parameter int DMEM_WORDS = 64
) (
   input logic clk,
   input logic reset
);
   mips_processor_if bus ();

   mips_core mips (.clk(clk), .reset(reset), .bus(bus.master));
   mips_imem #(.WORDS(IMEM_WORDS)) imem (.bus(bus.slave));
   mips_dmem #(.WORDS(DMEM_WORDS)) dmem (.clk(clk), .bus(bus.slave));
endmodule

// File: tb/tb_mips_processor.sv
// tb/tb_mips_processor.sv - directed programs with a register-expectation scoreboard
module tb_mips_processor;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      string       tag;
      int          idx;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] prog[$];

   mips_processor dut (.clk(clk), .reset(reset));

   always #5 clk = ~clk;

   function automatic logic [31:0] r_i(input int rs, input int rt, input int rd, input int f);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(f)};
   endfunction

   function automatic logic [31:0] i_i(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] j_i(input int op, input int target);
      return {6'(op), 26'(target)};
   endfunction

   task automatic run(input int ncyc);
      repeat (ncyc) @(posedge clk);
      #1;
   endtask

   // Hold reset while the ROM and register file are preloaded, then release and execute.
   task automatic start_prog(input int ncyc);
      reset = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 64; i++)
         dut.imem.INSTRROM[i] = (i < prog.size()) ? prog[i] : 32'd0;
      dut.mips.dp.gpr.registers[0] = 32'd0;
      for (int i = 1; i < 32; i++) dut.mips.dp.gpr.registers[i] = 32'hcafebabe;
      @(posedge clk);
      #1;
      reset = 1'b0;
      prog.delete();
      run(ncyc);
   endtask

   task automatic expect_reg(input string tag, input int idx, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.idx = idx;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic check_sb();
      exp_t        e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = dut.mips.dp.gpr.registers[e.idx];
         checks++;
         assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
         end
      end
   endtask

   initial begin
      // constants
      prog.push_back(i_i(6'h0f, 0, 1, 16'h1234));
      prog.push_back(i_i(6'h0d, 1, 1, 16'h5678));
      prog.push_back(i_i(6'h08, 0, 2, -1));
      expect_reg("const_r1", 1, 32'h12345678);
      expect_reg("const_r2", 2, 32'hffffffff);
      expect_reg("const_r3", 3, 32'hcafebabe);
      expect_reg("const_r31", 31, 32'hcafebabe);
      start_prog(3);
      check_sb();

      // bltz taken
      prog.push_back(i_i(6'h08, 0, 1, -5));
      prog.push_back(i_i(6'h01, 1, 0, 1));
      prog.push_back(i_i(6'h08, 0, 2, 7));
      prog.push_back(i_i(6'h08, 0, 3, 9));
      expect_reg("bltz_t_r1", 1, 32'hfffffffb);
      expect_reg("bltz_t_r2", 2, 32'hcafebabe);
      expect_reg("bltz_t_r3", 3, 32'h00000009);
      start_prog(4);
      check_sb();

      // bltz not taken on positive
      prog.push_back(i_i(6'h08, 0, 1, 5));
      prog.push_back(i_i(6'h01, 1, 0, 1));
      prog.push_back(i_i(6'h08, 0, 2, 7));
      prog.push_back(i_i(6'h08, 0, 3, 9));
      expect_reg("bltz_nt_r1", 1, 32'h00000005);
      expect_reg("bltz_nt_r2", 2, 32'h00000007);
      expect_reg("bltz_nt_r3", 3, 32'h00000009);
      start_prog(4);
      check_sb();

      // bltz on zero does not branch
      prog.push_back(i_i(6'h01, 0, 0, 1));
      prog.push_back(i_i(6'h08, 0, 2, 7));
      expect_reg("bltz_zero_r2", 2, 32'h00000007);
      start_prog(3);
      check_sb();

      // jal / jr
      prog.push_back(j_i(6'h03, 3));
      prog.push_back(i_i(6'h08, 0, 4, 1));
      prog.push_back(j_i(6'h02, 2));
      prog.push_back(i_i(6'h08, 0, 5, 2));
      prog.push_back(r_i(31, 0, 0, 6'b001000));
      expect_reg("call_r31", 31, 32'h00000004);
      expect_reg("call_r5", 5, 32'h00000002);
      expect_reg("call_r4", 4, 32'h00000001);
      start_prog(8);
      check_sb();

      // fibonacci, plus a write to $0
      prog.push_back(i_i(6'h08, 0, 1, 0));
      prog.push_back(i_i(6'h08, 0, 2, 1));
      prog.push_back(i_i(6'h08, 0, 3, 10));
      prog.push_back(i_i(6'h08, 0, 0, 1));
      prog.push_back(i_i(6'h04, 3, 0, 5));
      prog.push_back(r_i(1, 2, 4, 6'b100000));
      prog.push_back(r_i(2, 0, 1, 6'b100000));
      prog.push_back(r_i(4, 0, 2, 6'b100000));
      prog.push_back(i_i(6'h08, 3, 3, -1));
      prog.push_back(i_i(6'h04, 0, 0, -6));
      prog.push_back(j_i(6'h02, 10));
      expect_reg("fib_r1", 1, 32'h00000037);
      expect_reg("fib_r2", 2, 32'h00000059);
      expect_reg("fib_r3", 3, 32'h00000000);
      expect_reg("fib_r0", 0, 32'h00000000);
      start_prog(80);
      check_sb();

      // alu ops and unrecognised encodings
      prog.push_back(i_i(6'h08, 0, 1, -3));
      prog.push_back(i_i(6'h08, 0, 2, 4));
      prog.push_back(r_i(1, 2, 3, 6'b101010));
      prog.push_back(r_i(2, 1, 4, 6'b101010));
      prog.push_back(r_i(1, 2, 5, 6'b100010));
      prog.push_back(r_i(1, 2, 6, 6'b100100));
      prog.push_back(r_i(1, 2, 7, 6'b100101));
      prog.push_back(r_i(1, 2, 8, 6'b111111));
      prog.push_back(i_i(6'h3f, 1, 9, 16'h1234));
      expect_reg("slt_lt", 3, 32'h00000001);
      expect_reg("slt_ge", 4, 32'h00000000);
      expect_reg("sub", 5, 32'hfffffff9);
      expect_reg("and", 6, 32'h00000004);
      expect_reg("or", 7, 32'hfffffffd);
      expect_reg("bad_funct", 8, 32'hcafebabe);
      expect_reg("bad_op", 9, 32'hcafebabe);
      start_prog(10);
      check_sb();

      // memory, low address bits ignored
      prog.push_back(i_i(6'h08, 0, 1, 16'h55));
      prog.push_back(i_i(6'h2b, 0, 1, 8));
      prog.push_back(i_i(6'h23, 0, 2, 8));
      prog.push_back(i_i(6'h23, 0, 3, 11));
      prog.push_back(j_i(6'h02, 4));
      expect_reg("lw_r2", 2, 32'h00000055);
      expect_reg("lw_low_bits", 3, 32'h00000055);
      start_prog(6);
      check_sb();

      // reset mid-program: the instruction at PC during reset commits nothing
      prog.push_back(i_i(6'h08, 6, 6, 1));
      prog.push_back(i_i(6'h08, 7, 7, 1));
      prog.push_back(j_i(6'h02, 2));
      start_prog(1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      expect_reg("mid_reset_r6", 6, 32'hcafebabf);
      expect_reg("mid_reset_r7", 7, 32'hcafebabe);
      check_sb();
      run(1);
      expect_reg("restart_r6", 6, 32'hcafebac0);
      expect_reg("restart_r7", 7, 32'hcafebabe);
      check_sb();
      run(1);
      expect_reg("resume_r7", 7, 32'hcafebabf);
      check_sb();

      // multiply
      prog.push_back(i_i(6'h0f, 0, 1, 1));
      prog.push_back(i_i(6'h0f, 0, 2, 3));
      prog.push_back(r_i(1, 2, 0, 6'b011001));
      prog.push_back(r_i(0, 0, 3, 6'b010000));
      prog.push_back(r_i(0, 0, 4, 6'b010010));
      expect_reg("mul_r1", 1, 32'h00010000);
      expect_reg("mul_r2", 2, 32'h00030000);
`ifdef MUL_EN
      expect_reg("mfhi", 3, 32'h00000003);
      expect_reg("mflo", 4, 32'h00000000);
`else
      expect_reg("mfhi_nop", 3, 32'hcafebabe);
      expect_reg("mflo_nop", 4, 32'hcafebabe);
`endif
      start_prog(6);
      check_sb();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
